sensor_change_monitor: RTL and testbench

- Parametrised successor to the fixed 4-channel, 8-bit sensor co-processor.
- Tracks a baseline per sensor channel and flags a channel when a new sample differs from its baseline by more than a runtime threshold.
- Detected changes are queued as events in an internal FIFO with a valid/ready handshake, so the downstream LED/alert logic never misses an event.
- Sits between the sensor mux and the alert/LED driver.

---
 rtl/scm_pkg.sv | 24 ++
 rtl/sensor_change_monitor_if.sv | 44 ++++
 rtl/scm_event_fifo.sv | 62 ++++++
 rtl/sensor_change_monitor.sv | 124 ++++++++++++
 tb/tb_sensor_change_monitor.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scm_pkg.sv
// Shared types and helpers for the sensor change monitor.
// With SCM_TIMESTAMP_EN defined, event entries carry a 16-bit cycle timestamp.
package scm_pkg;

  localparam int TS_W      = 16;
  localparam int SCM_WIDTH = 8;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int SCM_CH_W = ch_w(4);

  // Event layout for the default 4-channel, 8-bit build
  typedef struct packed {
    logic [SCM_CH_W-1:0]  ch;
    logic [SCM_WIDTH-1:0] delta;
    logic                 up;
`ifdef SCM_TIMESTAMP_EN
    logic [TS_W-1:0]      ts;
`endif
  } scm_evt_t;

endpackage

// File: rtl/sensor_change_monitor_if.sv
// Sample input and event output bundle of the sensor change monitor.
// evt_ts exists only when SCM_TIMESTAMP_EN is defined.
interface sensor_change_monitor_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
);
  import scm_pkg::*;

  localparam int CW = ch_w(NUM_CH);

  logic                     in_valid;
  logic [WIDTH-1:0]         data_in;
  logic [CW-1:0]            ch_sel;
  logic [WIDTH-1:0]         thresh;
  logic                     evt_ready;
  logic                     clr_ovf;
  logic                     evt_valid;
  logic [CW-1:0]            evt_ch;
  logic [WIDTH-1:0]         evt_delta;
  logic                     evt_up;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   level;
`ifdef SCM_TIMESTAMP_EN
  logic [TS_W-1:0]          evt_ts;
`endif

  modport master (
    output in_valid, data_in, ch_sel, thresh, evt_ready, clr_ovf,
`ifdef SCM_TIMESTAMP_EN
    input  evt_ts,
`endif
    input  evt_valid, evt_ch, evt_delta, evt_up, overflow, level
  );

  modport slave (
    input  in_valid, data_in, ch_sel, thresh, evt_ready, clr_ovf,
`ifdef SCM_TIMESTAMP_EN
    output evt_ts,
`endif
    output evt_valid, evt_ch, evt_delta, evt_up, overflow, level
  );

endinterface

// File: rtl/scm_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only alongside a pop.
// The read port holds the last head entry while the FIFO is empty.
module scm_event_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          wdata_i,
  output logic [DW-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] hold_q;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? hold_q : mem_q[rd_q];

  always_comb begin
    rd_d  = pop_ok  ? rd_q + 1'b1 : rd_q;
    wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      hold_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_q] <= wdata_i;
      if (!empty_o) hold_q <= mem_q[rd_q];
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sensor_change_monitor.sv
// Per-channel baseline tracker that queues an event when a sample moves past the threshold.
// SCM_TIMESTAMP_EN adds a free-running cycle counter whose value is stored with each event.
module sensor_change_monitor
  import scm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
) (
  input logic                     clk,
  input logic                     reset,
  sensor_change_monitor_if.slave  bus
);

  localparam int CW = ch_w(NUM_CH);

  typedef struct packed {
    logic [CW-1:0]    ch;
    logic [WIDTH-1:0] delta;
    logic             up;
`ifdef SCM_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
  } evt_t;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [CW-1:0]    s1_ch_q;
  logic [WIDTH-1:0] base_q [NUM_CH];
  logic [NUM_CH-1:0] primed_q;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] base_sel;
  logic [WIDTH-1:0] diff;
  logic             up;
  logic             evt_gen;
  logic             base_wr;
  logic             fifo_full, fifo_empty;
  evt_t             push_evt, head;
  logic [$bits(evt_t)-1:0] fifo_rdata;

`ifdef SCM_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_q;
`endif

  // Larger minus smaller keeps the difference unsigned without wrap
  assign base_sel = base_q[s1_ch_q];
  assign up       = (s1_data_q > base_sel);
  assign diff     = up ? (s1_data_q - base_sel) : (base_sel - s1_data_q);
  assign evt_gen  = s1_valid_q & primed_q[s1_ch_q] & (diff > bus.thresh);
  assign base_wr  = s1_valid_q & (~primed_q[s1_ch_q] | evt_gen);

  always_comb begin
    push_evt       = '0;
    push_evt.ch    = s1_ch_q;
    push_evt.delta = diff;
    push_evt.up    = up;
`ifdef SCM_TIMESTAMP_EN
    push_evt.ts    = ts_q;
`endif
  end

  // A dropped push wins over a clear in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    if (evt_gen && fifo_full && !bus.evt_ready) ovf_d = 1'b1;
    else if (bus.clr_ovf)                       ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_ch_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) base_q[i] <= '0;
      primed_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_q <= bus.data_in;
        s1_ch_q   <= bus.ch_sel;
      end
      if (base_wr) begin
        base_q[s1_ch_q]   <= s1_data_q;
        primed_q[s1_ch_q] <= 1'b1;
      end
      ovf_q <= ovf_d;
    end
  end

`ifdef SCM_TIMESTAMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end
`endif

  scm_event_fifo #(
    .DW    ($bits(evt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (evt_gen),
    .pop_i   (bus.evt_ready),
    .wdata_i (push_evt),
    .rdata_o (fifo_rdata),
    .count_o (bus.level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head          = evt_t'(fifo_rdata);
  assign bus.evt_valid = ~fifo_empty;
  assign bus.evt_ch    = head.ch;
  assign bus.evt_delta = head.delta;
  assign bus.evt_up    = head.up;
  assign bus.overflow  = ovf_q;
`ifdef SCM_TIMESTAMP_EN
  assign bus.evt_ts    = head.ts;
`endif

endmodule

// File: tb/tb_sensor_change_monitor.sv
// Scoreboard bench for sensor_change_monitor: reference model at posedge, monitor at negedge.
module tb_sensor_change_monitor;
  import scm_pkg::*;

  localparam int W = 8;
  localparam int N = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sensor_change_monitor_if #(.WIDTH(W), .NUM_CH(N), .DEPTH(D)) bus ();

  sensor_change_monitor #(.WIDTH(W), .NUM_CH(N), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  // reference model state
  scm_evt_t    scb[$];
  scm_evt_t    last = '0;
  int          mbase[N];
  bit          mprimed[N];
  int          mlevel = 0;
  bit          movf = 0;
  bit          pend_v = 0;
  int          pend_c = 0;
  int          pend_d = 0;
  logic [15:0] mts = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mbase[i]   = 0;
      mprimed[i] = 0;
    end
    scb.delete();
    last   = '0;
    mlevel = 0;
    movf   = 0;
    pend_v = 0;
    mts    = '0;
  endtask

  task automatic model_step();
    bit       ev;
    bit       pop;
    int       d;
    scm_evt_t e;
    ev = 0;
    e  = '0;
    if (pend_v) begin
      if (!mprimed[pend_c]) begin
        mbase[pend_c]   = pend_d;
        mprimed[pend_c] = 1;
      end else begin
        d = (pend_d > mbase[pend_c]) ? pend_d - mbase[pend_c] : mbase[pend_c] - pend_d;
        if (d > int'(bus.thresh)) begin
          e.ch    = 2'(pend_c);
          e.delta = 8'(d);
          e.up    = (pend_d > mbase[pend_c]);
`ifdef SCM_TIMESTAMP_EN
          e.ts    = mts;
`endif
          ev = 1;
          mbase[pend_c] = pend_d;
        end
      end
    end
    pop = (mlevel > 0) && bus.evt_ready;
    if (ev && mlevel == D && !pop) begin
      movf = 1;
    end else begin
      if (bus.clr_ovf) movf = 0;
      if (ev) begin
        scb.push_back(e);
        mlevel++;
      end
    end
    if (pop) mlevel--;
    pend_v = bus.in_valid;
    pend_c = int'(bus.ch_sel);
    pend_d = int'(bus.data_in);
    mts    = mts + 16'd1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // monitor: compares DUT outputs against the model and scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (started && !reset) begin
        chk("evt_valid", 32'(bus.evt_valid), 32'(mlevel != 0));
        chk("level", 32'(bus.level), 32'(mlevel));
        chk("overflow", 32'(bus.overflow), 32'(movf));
        if (bus.evt_valid) begin
          if (scb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL head_unexpected: got ch %0d delta 0x%0h, expected no event", bus.evt_ch, bus.evt_delta);
          end else begin
            chk("head_ch", 32'(bus.evt_ch), 32'(scb[0].ch));
            chk("head_delta", 32'(bus.evt_delta), 32'(scb[0].delta));
            chk("head_up", 32'(bus.evt_up), 32'(scb[0].up));
`ifdef SCM_TIMESTAMP_EN
            chk("head_ts", 32'(bus.evt_ts), 32'(scb[0].ts));
`endif
            if (bus.evt_ready) last = scb.pop_front();
          end
        end else begin
          chk("hold_ch", 32'(bus.evt_ch), 32'(last.ch));
          chk("hold_delta", 32'(bus.evt_delta), 32'(last.delta));
          chk("hold_up", 32'(bus.evt_up), 32'(last.up));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input int ch, input int d);
    bus.in_valid = 1'b1;
    bus.ch_sel   = 2'(ch);
    bus.data_in  = 8'(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.ch_sel    = '0;
    bus.thresh    = 8'd2;
    bus.evt_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    started = 1;
    chk("reset_level", 32'(bus.level), 32'd0);
    chk("reset_valid", 32'(bus.evt_valid), 32'd0);

    // priming and threshold boundary
    drive(0, 8'h10);
    drive(1, 8'h20);
    drive(0, 8'h12);
    drive(0, 8'h13);
    idle(3);
    chk("t1_level", 32'(bus.level), 32'd1);
    chk("t1_ch", 32'(bus.evt_ch), 32'd0);
    chk("t1_delta", 32'(bus.evt_delta), 32'd3);
    chk("t1_up", 32'(bus.evt_up), 32'd1);
    bus.evt_ready = 1'b1;
    idle(2);
    bus.evt_ready = 1'b0;

    // full-scale downward change, then diff equal to all-ones threshold
    drive(2, 8'hFF);
    drive(2, 8'h00);
    idle(2);
    chk("t2_ch", 32'(bus.evt_ch), 32'd2);
    chk("t2_delta", 32'(bus.evt_delta), 32'hFF);
    chk("t2_up", 32'(bus.evt_up), 32'd0);
    bus.evt_ready = 1'b1;
    idle(2);
    bus.thresh = 8'hFF;
    drive(2, 8'hFF);
    idle(3);
    chk("t2_thr_ff_level", 32'(bus.level), 32'd0);
    bus.thresh = 8'd2;

    // back-to-back on one channel
    drive(3, 8'h40);
    drive(3, 8'h50);
    drive(3, 8'h51);
    drive(3, 8'h60);
    idle(4);

    // overflow and clear
    bus.evt_ready = 1'b0;
    drive(0, 8'h30);
    drive(0, 8'h50);
    drive(1, 8'h40);
    drive(1, 8'h60);
    drive(0, 8'h70);
    idle(2);
    chk("t4_level_full", 32'(bus.level), 32'd4);
    chk("t4_ovf_set", 32'(bus.overflow), 32'd1);
    bus.evt_ready = 1'b1;
    idle(5);
    bus.evt_ready = 1'b0;
    chk("t4_drained", 32'(bus.level), 32'd0);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(bus.overflow), 32'd0);
    drive(0, 8'h10);
    drive(0, 8'h40);
    drive(1, 8'h10);
    drive(1, 8'h40);
    idle(1);
    drive(0, 8'h90);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("t4_set_beats_clr", 32'(bus.overflow), 32'd1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;

    // full FIFO with simultaneous push and pop
    drive(1, 8'h90);
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
    chk("t5_level", 32'(bus.level), 32'd4);
    chk("t5_ovf", 32'(bus.overflow), 32'd0);
    bus.evt_ready = 1'b1;
    idle(6);
    bus.evt_ready = 1'b0;

    // reset with queued events and a sample in flight
    drive(2, 8'h80);
    drive(2, 8'h00);
    idle(1);
    bus.in_valid = 1'b1;
    bus.ch_sel   = 2'd1;
    bus.data_in  = 8'hF0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    bus.in_valid = 1'b0;
    chk("rst_valid", 32'(bus.evt_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_ch", 32'(bus.evt_ch), 32'd0);
    chk("rst_delta", 32'(bus.evt_delta), 32'd0);
    chk("rst_up", 32'(bus.evt_up), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 8'h05);
    idle(3);
    chk("post_rst_prime", 32'(bus.level), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(3))
          0:       bus.thresh = 8'd0;
          1:       bus.thresh = 8'd2;
          2:       bus.thresh = 8'hFF;
          default: bus.thresh = 8'($urandom_range(255));
        endcase
      end
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.ch_sel    = 2'($urandom_range(N - 1));
      bus.data_in   = 8'($urandom_range(255));
      bus.evt_ready = ($urandom_range(2) == 0);
      bus.clr_ovf   = ($urandom_range(9) == 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.clr_ovf   = 1'b0;
    bus.evt_ready = 1'b1;
    idle(8);
    chk("final_drain", 32'(bus.level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
